// File: rtl/regfile_commit_sequencer_pkg.sv
// regfile_commit_sequencer_pkg: commit entry/flag types and GPR/ROB width macros shared by the commit path
`ifndef GPR_IDX_SIZE
`define GPR_IDX_SIZE 5
`endif
`ifndef GPR_SIZE
`define GPR_SIZE 32
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif
package regfile_commit_sequencer_pkg;
  localparam int GIW = `GPR_IDX_SIZE;
  localparam int GW = `GPR_SIZE;
  localparam int RIW = `ROB_IDX_SIZE;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;
  typedef struct packed {
    logic [GIW-1:0] reg_index;
    logic [GW-1:0]  value;
    logic [RIW-1:0] rob_index;
    logic           set_nzcv;
    nzcv_t          nzcv;
  } commit_entry_t;
endpackage

// File: rtl/regfile_commit_sequencer_fifo.sv
// commit_fifo: 2-write/1-read circular FIFO of commit entries with count and flush
module commit_fifo
  import regfile_commit_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic                         in_flush,
  input  logic [1:0]                   in_wr_en,
  input  commit_entry_t [1:0]          in_wr_data,
  input  logic                         in_rd_en,
  output commit_entry_t                out_rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   out_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  commit_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [1:0] w_n_push;
  commit_entry_t w_first;
  assign w_n_push = {1'b0, in_wr_en[0]} + {1'b0, in_wr_en[1]};
  // a lone lane-1 write still lands at the tail slot
  assign w_first = in_wr_en[0] ? in_wr_data[0] : in_wr_data[1];
  always_ff @(posedge in_clk) begin
    if (!in_rst && !in_flush) begin
      if (|in_wr_en) r_mem[r_tail] <= w_first;
      if (&in_wr_en) r_mem[r_tail + PW'(1)] <= in_wr_data[1];
    end
  end
  always_ff @(posedge in_clk) begin
    if (in_rst || in_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      r_tail <= r_tail + PW'(w_n_push);
      r_head <= r_head + PW'(in_rd_en);
      r_count <= r_count + CW'(w_n_push) - CW'(in_rd_en);
    end
  end
  assign out_rd_data = r_mem[r_head];
  assign out_count = r_count;
endmodule

// File: rtl/regfile_commit_sequencer.sv
// regfile_commit_sequencer: buffers 2-wide ROB retires into 1 regfile commit/cycle; REGFILE_COMMIT_BYPASS_EN adds empty-FIFO lane-0 bypass
module regfile_commit_sequencer
  import regfile_commit_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic [1:0]                  in_rob_commit_valid,
  input  logic [1:0][GIW-1:0]         in_rob_reg_index,
  input  logic [1:0][GW-1:0]          in_rob_commit_value,
  input  logic [1:0][RIW-1:0]         in_rob_commit_rob_index,
  input  logic [1:0]                  in_rob_set_nzcv,
  input  nzcv_t [1:0]                 in_rob_nzcv,
  input  logic                        in_flush,
  output logic                        out_rob_commit_ready,
  output logic                        out_reg_should_commit,
  output logic [GIW-1:0]              out_reg_reg_index,
  output logic [GW-1:0]               out_reg_commit_value,
  output logic [RIW-1:0]              out_reg_commit_rob_index,
  output logic                        out_reg_set_nzcv,
  output nzcv_t                       out_reg_nzcv,
  output logic [$clog2(DEPTH+1)-1:0]  out_occupancy,
  output logic                        out_overflow
);
  localparam int CW = $clog2(DEPTH + 1);
  commit_entry_t [1:0] w_lane;
  commit_entry_t w_head, w_out, r_entry;
  logic [CW-1:0] w_count;
  logic [1:0] w_accept, w_push;
  logic w_bypass, w_pop, r_should_commit, r_overflow;
  for (genvar i = 0; i < 2; i++) begin : g_lane
    assign w_lane[i] = '{reg_index: in_rob_reg_index[i], value: in_rob_commit_value[i],
                         rob_index: in_rob_commit_rob_index[i], set_nzcv: in_rob_set_nzcv[i],
                         nzcv: in_rob_nzcv[i]};
  end
  assign out_rob_commit_ready = w_count <= CW'(DEPTH - 2);
  assign w_accept = in_rob_commit_valid & {2{out_rob_commit_ready & ~in_flush}};
`ifdef REGFILE_COMMIT_BYPASS_EN
  // only when no registered commit is already on the port this cycle
  assign w_bypass = w_accept[0] && w_count == '0 && !r_should_commit;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_push = {w_accept[1], w_accept[0] & ~w_bypass};
  assign w_pop = w_count != '0 && !in_flush;
  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .in_flush   (in_flush),
    .in_wr_en   (w_push),
    .in_wr_data (w_lane),
    .in_rd_en   (w_pop),
    .out_rd_data(w_head),
    .out_count  (w_count)
  );
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_should_commit <= 1'b0;
      r_entry <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_should_commit <= w_pop;
      r_entry <= w_pop ? w_head : w_bypass ? w_lane[0] : r_entry;
      r_overflow <= r_overflow | (|in_rob_commit_valid & ~out_rob_commit_ready & ~in_flush);
    end
  end
  assign w_out = w_bypass ? w_lane[0] : r_entry;
  assign out_reg_should_commit = r_should_commit | w_bypass;
  assign out_reg_reg_index = w_out.reg_index;
  assign out_reg_commit_value = w_out.value;
  assign out_reg_commit_rob_index = w_out.rob_index;
  assign out_reg_set_nzcv = w_out.set_nzcv;
  assign out_reg_nzcv = w_out.nzcv;
  assign out_occupancy = w_count;
  assign out_overflow = r_overflow;
endmodule
